// File: rtl/pc_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and its memory.
interface pc_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch.sv
// Instruction fetch stage: single-outstanding imem requests, redirect handling
// with response drop, and an output register backed by a one-entry skid buffer.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  pc_fetch_if.master   imem,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  input  logic         stall,
  output logic         if_valid,
  output logic [31:0]  if_pc,
  output logic [31:0]  if_pc4,
  output logic [31:0]  if_inst
);

  localparam logic [31:0] START_PC = RESET_PC & ~32'h3;

  typedef enum logic [1:0] {FETCH, WAIT, DROP} state_t;

  state_t      state_reg, state_next;
  logic [31:0] fetch_pc_reg, fetch_pc_next;
  logic        run_reg;
  logic        out_valid_reg, out_valid_next;
  logic [31:0] out_pc_reg, out_pc_next;
  logic [31:0] out_pc4_reg, out_pc4_next;
  logic [31:0] out_inst_reg, out_inst_next;
  logic        skid_valid_reg, skid_valid_next;
  logic [31:0] skid_pc_reg, skid_pc_next;
  logic [31:0] skid_inst_reg, skid_inst_next;

  logic req, grant, resp;

  // run_reg keeps imem_req low until the first edge after reset release
  assign req            = run_reg && (state_reg == FETCH) && !skid_valid_reg;
  assign grant          = req && imem.imem_gnt;
  assign resp           = (state_reg == WAIT) && imem.imem_rvalid;
  assign imem.imem_req  = req;
  assign imem.imem_addr = fetch_pc_reg;
  assign if_valid       = out_valid_reg;
  assign if_pc          = out_pc_reg;
  assign if_pc4         = out_pc4_reg;
  assign if_inst        = out_inst_reg;

  always_comb begin
    state_next      = state_reg;
    fetch_pc_next   = fetch_pc_reg;
    out_valid_next  = out_valid_reg;
    out_pc_next     = out_pc_reg;
    out_pc4_next    = out_pc4_reg;
    out_inst_next   = out_inst_reg;
    skid_valid_next = skid_valid_reg;
    skid_pc_next    = skid_pc_reg;
    skid_inst_next  = skid_inst_reg;

    if (redirect) begin
      fetch_pc_next   = redirect_pc & ~32'h3;
      out_valid_next  = 1'b0;
      skid_valid_next = 1'b0;
      // A response landing in the redirect cycle is discarded here, so DROP
      // must not wait for another one that will never come.
      case (state_reg)
        FETCH:      state_next = grant ? DROP : FETCH;
        WAIT, DROP: state_next = imem.imem_rvalid ? FETCH : DROP;
        default:    state_next = FETCH;
      endcase
    end else begin
      case (state_reg)
        FETCH: begin
          if (grant) begin
            fetch_pc_next = fetch_pc_reg + 32'd4;
            state_next    = WAIT;
          end
        end
        WAIT, DROP: begin
          if (imem.imem_rvalid) state_next = FETCH;
        end
        default: state_next = FETCH;
      endcase

      if (!stall) begin
        if (skid_valid_reg) begin
          out_valid_next  = 1'b1;
          out_pc_next     = skid_pc_reg;
          out_pc4_next    = skid_pc_reg + 32'd4;
          out_inst_next   = skid_inst_reg;
          skid_valid_next = resp;
          if (resp) begin
            skid_pc_next   = fetch_pc_reg - 32'd4;
            skid_inst_next = imem.imem_rdata;
          end
        end else if (resp) begin
          out_valid_next = 1'b1;
          out_pc_next    = fetch_pc_reg - 32'd4;
          out_pc4_next   = fetch_pc_reg;
          out_inst_next  = imem.imem_rdata;
        end else begin
          out_valid_next = 1'b0;
        end
      end else if (resp) begin
        if (!out_valid_reg) begin
          out_valid_next = 1'b1;
          out_pc_next    = fetch_pc_reg - 32'd4;
          out_pc4_next   = fetch_pc_reg;
          out_inst_next  = imem.imem_rdata;
        end else begin
          skid_valid_next = 1'b1;
          skid_pc_next    = fetch_pc_reg - 32'd4;
          skid_inst_next  = imem.imem_rdata;
        end
      end
    end
  end

  // In WAIT, fetch_pc already points one word past the outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= FETCH;
      fetch_pc_reg   <= START_PC;
      run_reg        <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_pc_reg     <= 32'h0;
      out_pc4_reg    <= 32'h0;
      out_inst_reg   <= 32'h0;
      skid_valid_reg <= 1'b0;
      skid_pc_reg    <= 32'h0;
      skid_inst_reg  <= 32'h0;
    end else begin
      state_reg      <= state_next;
      fetch_pc_reg   <= fetch_pc_next;
      run_reg        <= 1'b1;
      out_valid_reg  <= out_valid_next;
      out_pc_reg     <= out_pc_next;
      out_pc4_reg    <= out_pc4_next;
      out_inst_reg   <= out_inst_next;
      skid_valid_reg <= skid_valid_next;
      skid_pc_reg    <= skid_pc_next;
      skid_inst_reg  <= skid_inst_next;
    end
  end

endmodule
